bt656_422_encoder: RTL
======================

Name: bt656_422_encoder

Overview:
- Downstream stage of the SD test-pattern generator.
- Consumes the per-pixel 8-bit RGB and the h/v/active timing from the sync generator.
- Converts RGB to BT.601 YCbCr and decimates chroma to 4:2:2.
- Emits a 16-bit Y/C bus with embedded EAV/SAV timing reference codes, ready for a serializer or an SDI/HDMI bridge.

Parameters:
- H_ACTIVE, 720, active pixels per line
- H_TOTAL, 858, total pixels per line
- V_ACTIVE, 480, active lines per frame
- V_TOTAL, 525, total lines per frame

Ports:
- clk_pix  input  1  pixel clock; single clock domain
- rst  input  1  reset, synchronous to clk_pix, active-high
- h_in  input  13  horizontal pixel counter from the sync generator; 0 = first active pixel
- v_in  input  13  vertical line counter; 0 = first active line
- active_in  input  1  active-video flag from the sync generator
- r_in  input  8  red, studio range
- g_in  input  8  green, studio range
- b_in  input  8  blue, studio range
- y_out  output  8  luma, or timing-code word
- c_out  output  8  multiplexed Cb/Cr, or timing-code word
- code_out  output  1  high while y_out/c_out carry an EAV/SAV word
- de_out  output  1  high while y_out/c_out carry active picture data

Behaviour:
- Reset and clocking:
  - The clock and reset are fixed as one clock, clk_pix, with synchronous active-high reset rst.
  - While rst is high, and on the first clock after rst falls: y_out=0x10, c_out=0x80, code_out=0, de_out=0, all pipeline stages cleared.
  - Reset asserted mid-line takes effect on the next edge; any partial EAV/SAV is abandoned.
- Latency:
  - Fixed 3 clk_pix from input sample to output, for data, codes and flags alike.
  - h_in, v_in and active_in are delayed alongside the data.
  - After reset, the first 3 output cycles are blanking (0x10/0x80).
- Colour conversion (signed, at least 18-bit intermediates, round by +128 then arithmetic >>8):
  - Y = (77R + 150G + 29B + 128) >> 8
  - Cb = 128 + ((-44R - 87G + 131B + 128) >> 8)
  - Cr = 128 + ((131R - 110G - 21B + 128) >> 8)
  - Every active-data result is clipped to 0x01..0xFE; 0x00 and 0xFF are reserved for timing codes.
- Chroma decimation (co-sited):
  - Even h: c_out = Cb of pixel h.
  - Odd h: c_out = Cr of pixel h-1, held in a one-pixel register; the Cr of odd pixels is discarded.
- Output selection, evaluated on the delayed h/v:
  - EAV at h = H_ACTIVE .. H_ACTIVE+3.
  - SAV at h = H_TOTAL-4 .. H_TOTAL-1.
  - Active data when the delayed active_in = 1 and h < H_ACTIVE and v < V_ACTIVE; de_out=1.
  - Everything else is blanking: y_out=0x10, c_out=0x80.
  - Any h >= H_TOTAL or v >= V_TOTAL is treated as blanking with no code.
- Timing code words:
  - Four words, identical on y_out and c_out: 0xFF, 0x00, 0x00, XY. code_out=1 for all four.
  - XY = {1, F, V, H, V^H, F^H, F^V, F^V^H}, with F=0 (progressive).
  - H=1 for EAV, H=0 for SAV.
  - EAV: V = (v >= V_ACTIVE) for the current line.
  - SAV: V is evaluated on the next line, (v+1) mod V_TOTAL, so the SAV on line V_TOTAL-1 carries V=0.
  - Resulting XY values: SAV active 0x80, EAV active 0x9D, SAV blank 0xAB, EAV blank 0xB6.
- Mutual exclusion and flag consistency:
  - Code and data regions are mutually exclusive by construction; codes take priority if active_in is asserted erroneously inside a code window.
  - code_out and de_out are never high together.

Test Plan:
1. Reset mid-line:
   - Stimulus: rst high for 2 cycles at h=300, v=10.
   - Required: outputs read 0x10/0x80 with code_out=0 and de_out=0 through reset and 3 cycles after; normal data resumes at the 4th cycle after rst falls.
2. Solid 75% blue (0x10,0x10,0xB4), line v=0:
   - Required: 3 cycles later, y_out=0x23 on every active pixel; c_out alternates 0xD4 (Cb) / 0x73 (Cr); de_out=1 for exactly 720 cycles.
3. White 0xEB and super-black 0x00:
   - White: Y=0xEB, Cb=Cr=0x80.
   - Super-black: Y clipped to 0x01, C=0x80; no 0x00 ever appears with de_out=1.
4. Full-frame sweep:
   - EAV on v=0: FF,00,00,9D.
   - SAV ending v=479: XY=AB.
   - EAV on v=480: B6.
   - SAV ending v=524: XY=80 (wrap to active line 0).
   - code_out high for exactly 4 cycles per code; 2 codes per line.
5. Chroma alternation with per-pixel changing RGB:
   - Stimulus: red at even h, blue at odd h.
   - Required: c_out at every odd h equals the Cr of red (0xF0); the blue pixel's chroma is never emitted.
6. Out-of-range timing:
   - Stimulus: h_in=900, active_in=1.
   - Required: blanking output, code_out=0, de_out=0.

Source files
------------

// File: rtl/bt656_422_encoder.sv
// BT.656-style 4:2:2 encoder: RGB -> BT.601 YCbCr, co-sited chroma decimation,
// EAV/SAV insertion. Three register stages from input sample to output.
module bt656_422_encoder #(
    parameter int H_ACTIVE = 720,
    parameter int H_TOTAL  = 858,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525
) (
    input  logic        clk_pix,
    input  logic        rst,
    input  logic [12:0] h_in,
    input  logic [12:0] v_in,
    input  logic        active_in,
    input  logic [7:0]  r_in,
    input  logic [7:0]  g_in,
    input  logic [7:0]  b_in,
    output logic [7:0]  y_out,
    output logic [7:0]  c_out,
    output logic        code_out,
    output logic        de_out
);

    localparam logic [12:0] H_ACT_L   = 13'(H_ACTIVE);
    localparam logic [12:0] EAV_END_L = 13'(H_ACTIVE + 4);
    localparam logic [12:0] SAV_L     = 13'(H_TOTAL - 4);
    localparam logic [12:0] H_TOT_L   = 13'(H_TOTAL);
    localparam logic [12:0] V_ACT_L   = 13'(V_ACTIVE);
    localparam logic [12:0] V_TOT_L   = 13'(V_TOTAL);
    localparam logic [12:0] V_LAST_L  = 13'(V_TOTAL - 1);

    function automatic logic signed [19:0] round_shift(input logic signed [19:0] acc);
        return (acc + 20'sd128) >>> 8;
    endfunction

    // 0x00 and 0xFF are reserved for timing reference words.
    function automatic logic [7:0] clip_data(input logic signed [19:0] val);
        if (val < 20'sd1)
            return 8'h01;
        else if (val > 20'sd254)
            return 8'hFE;
        else
            return 8'(val);
    endfunction

    logic [7:0]  r_p0_q, g_p0_q, b_p0_q, r_p0_d, g_p0_d, b_p0_d;
    logic [12:0] h_p0_q, v_p0_q, h_p0_d, v_p0_d;
    logic        act_p0_q, act_p0_d, vld_p0_q, vld_p0_d;

    logic [7:0]  y_p1_q, cb_p1_q, cr_p1_q, y_p1_d, cb_p1_d, cr_p1_d;
    logic [12:0] h_p1_q, v_p1_q, h_p1_d, v_p1_d;
    logic        act_p1_q, act_p1_d, vld_p1_q, vld_p1_d;

    logic [7:0]  y_p2_q, c_p2_q, y_p2_d, c_p2_d;
    logic        code_p2_q, de_p2_q, code_p2_d, de_p2_d;
    logic [7:0]  cr_hold_q, cr_hold_d;

    logic signed [19:0] r_s, g_s, b_s, y_acc, cb_acc, cr_acc;
    logic        in_range, eav, sav, data_en, v_bit, h_bit;
    logic [12:0] v_next;
    logic [1:0]  widx;
    logic [7:0]  xy, word;

    // Stage p0: input capture
    always_comb begin
        r_p0_d   = r_in;
        g_p0_d   = g_in;
        b_p0_d   = b_in;
        h_p0_d   = h_in;
        v_p0_d   = v_in;
        act_p0_d = active_in;
        vld_p0_d = 1'b1;
    end

    // Stage p1: colour-space conversion
    always_comb begin
        r_s      = signed'({12'd0, r_p0_q});
        g_s      = signed'({12'd0, g_p0_q});
        b_s      = signed'({12'd0, b_p0_q});
        y_acc    = 20'sd77 * r_s + 20'sd150 * g_s + 20'sd29 * b_s;
        cb_acc   = 20'sd131 * b_s - 20'sd44 * r_s - 20'sd87 * g_s;
        cr_acc   = 20'sd131 * r_s - 20'sd110 * g_s - 20'sd21 * b_s;
        y_p1_d   = clip_data(round_shift(y_acc));
        cb_p1_d  = clip_data(20'sd128 + round_shift(cb_acc));
        cr_p1_d  = clip_data(20'sd128 + round_shift(cr_acc));
        h_p1_d   = h_p0_q;
        v_p1_d   = v_p0_q;
        act_p1_d = act_p0_q;
        vld_p1_d = vld_p0_q;
    end

    // Stage p2: region decode, code words, chroma multiplex
    always_comb begin
        y_p2_d    = 8'h10;
        c_p2_d    = 8'h80;
        code_p2_d = 1'b0;
        de_p2_d   = 1'b0;
        cr_hold_d = cr_hold_q;

        in_range = vld_p1_q && (h_p1_q < H_TOT_L) && (v_p1_q < V_TOT_L);
        eav      = in_range && (h_p1_q >= H_ACT_L) && (h_p1_q < EAV_END_L);
        sav      = in_range && (h_p1_q >= SAV_L);
        data_en  = in_range && act_p1_q && (h_p1_q < H_ACT_L) && (v_p1_q < V_ACT_L);

        // SAV announces the line that follows, so its V flag looks one line ahead.
        v_next = (v_p1_q == V_LAST_L) ? 13'd0 : v_p1_q + 13'd1;
        v_bit  = eav ? (v_p1_q >= V_ACT_L) : (v_next >= V_ACT_L);
        h_bit  = eav;
        xy     = {1'b1, 1'b0, v_bit, h_bit, v_bit ^ h_bit, h_bit, v_bit, v_bit ^ h_bit};
        widx   = eav ? 2'(h_p1_q - H_ACT_L) : 2'(h_p1_q - SAV_L);
        case (widx)
            2'd0:    word = 8'hFF;
            2'd3:    word = xy;
            default: word = 8'h00;
        endcase

        if (vld_p1_q && !h_p1_q[0])
            cr_hold_d = cr_p1_q;

        if (eav || sav) begin
            y_p2_d    = word;
            c_p2_d    = word;
            code_p2_d = 1'b1;
        end else if (data_en) begin
            y_p2_d  = y_p1_q;
            c_p2_d  = h_p1_q[0] ? cr_hold_q : cb_p1_q;
            de_p2_d = 1'b1;
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            r_p0_q    <= 8'd0;
            g_p0_q    <= 8'd0;
            b_p0_q    <= 8'd0;
            h_p0_q    <= 13'd0;
            v_p0_q    <= 13'd0;
            act_p0_q  <= 1'b0;
            vld_p0_q  <= 1'b0;
            y_p1_q    <= 8'h10;
            cb_p1_q   <= 8'h80;
            cr_p1_q   <= 8'h80;
            h_p1_q    <= 13'd0;
            v_p1_q    <= 13'd0;
            act_p1_q  <= 1'b0;
            vld_p1_q  <= 1'b0;
            y_p2_q    <= 8'h10;
            c_p2_q    <= 8'h80;
            code_p2_q <= 1'b0;
            de_p2_q   <= 1'b0;
            cr_hold_q <= 8'h80;
        end else begin
            r_p0_q    <= r_p0_d;
            g_p0_q    <= g_p0_d;
            b_p0_q    <= b_p0_d;
            h_p0_q    <= h_p0_d;
            v_p0_q    <= v_p0_d;
            act_p0_q  <= act_p0_d;
            vld_p0_q  <= vld_p0_d;
            y_p1_q    <= y_p1_d;
            cb_p1_q   <= cb_p1_d;
            cr_p1_q   <= cr_p1_d;
            h_p1_q    <= h_p1_d;
            v_p1_q    <= v_p1_d;
            act_p1_q  <= act_p1_d;
            vld_p1_q  <= vld_p1_d;
            y_p2_q    <= y_p2_d;
            c_p2_q    <= c_p2_d;
            code_p2_q <= code_p2_d;
            de_p2_q   <= de_p2_d;
            cr_hold_q <= cr_hold_d;
        end
    end

    assign y_out    = y_p2_q;
    assign c_out    = c_p2_q;
    assign code_out = code_p2_q;
    assign de_out   = de_p2_q;

endmodule
